// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package : HighLevelControl
// Brief   : Shared control types: truncation/size code, memory-stage states,
//           and the byte-count helper used by the load/store unit.
// Rev     : 1.0 - initial release
// ============================================================================
package HighLevelControl;

  // Access size and sign code; it travels with the result to writeback.
  typedef enum logic [2:0] {
    BYTE               = 3'd0,
    HALF_WORD          = 3'd1,
    WORD               = 3'd2,
    BYTE_UNSIGNED      = 3'd3,
    HALF_WORD_UNSIGNED = 3'd4,
    NO_TRUNC           = 3'd5
  } truncSrc;

  // Load/store unit sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    RESP   = 2'd3
  } memState;

  // Number of bytes moved for a given size code.
  function automatic logic [2:0] sizeOf(input truncSrc t);
    case (t)
      BYTE, BYTE_UNSIGNED:           sizeOf = 3'd1;
      HALF_WORD, HALF_WORD_UNSIGNED: sizeOf = 3'd2;
      default:                       sizeOf = 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_lane_shifter.sv
`default_nettype none
// ============================================================================
// Module : lane_shifter
// Brief  : Combinational byte-lane shifter. Produces the lane enables and
//          lane-positioned store data for both beats of an access, and the
//          lane-0 aligned load result from the two read words.
// Rev    : 1.0 - initial release
// ============================================================================
module lane_shifter #(
  parameter int BIT_COUNT = 32
) (
  input  logic [1:0]             off,
  input  logic [2:0]             size,
  input  logic [BIT_COUNT-1:0]   store_data,
  input  logic [BIT_COUNT-1:0]   lo_word,
  input  logic [BIT_COUNT-1:0]   hi_word,
  output logic [BIT_COUNT/8-1:0] lo_be,
  output logic [BIT_COUNT/8-1:0] hi_be,
  output logic [BIT_COUNT-1:0]   lo_wdata,
  output logic [BIT_COUNT-1:0]   hi_wdata,
  output logic [BIT_COUNT-1:0]   load_data,
  output logic                   span
);

  localparam int LANES = BIT_COUNT / 8;

  logic [LANES-1:0]       size_mask;
  logic [2*LANES-1:0]     be_wide;
  logic [2*BIT_COUNT-1:0] wd_wide;
  logic [2*BIT_COUNT-1:0] rd_wide;
  logic [BIT_COUNT-1:0]   keep_mask;

  // Shift a double-width view so the part spilling past lane 3 lands in the hi beat.
  always_comb begin
    size_mask = LANES'((1 << size) - 1);
    be_wide   = {{LANES{1'b0}}, size_mask} << off;
    wd_wide   = {{BIT_COUNT{1'b0}}, store_data} << {off, 3'b000};
    rd_wide   = {hi_word, lo_word} >> {off, 3'b000};
    keep_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      keep_mask[8*i +: 8] = {8{size_mask[i]}};
    end
    lo_be     = be_wide[LANES-1:0];
    hi_be     = be_wide[2*LANES-1:LANES];
    lo_wdata  = wd_wide[BIT_COUNT-1:0];
    hi_wdata  = wd_wide[2*BIT_COUNT-1:BIT_COUNT];
    load_data = rd_wide[BIT_COUNT-1:0] & keep_mask;
    span      = ({1'b0, off} + size) > 3'd4;
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module : mem_access_unit
// Brief  : Memory-stage load/store unit. Splits word-crossing accesses into
//          two aligned bus beats, stalls the pipeline until the bus acks and
//          returns load data shifted down to byte lane 0.
// Rev    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import HighLevelControl::*;
#(
  parameter int BIT_COUNT = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   MemReq,
  input  logic                   MemWrite,
  input  truncSrc                TruncSrc,
  input  logic [BIT_COUNT-1:0]   Address,
  input  logic [BIT_COUNT-1:0]   WriteData,
  output logic                   Stall,
  output logic                   LoadValid,
  output logic [BIT_COUNT-1:0]   LoadData,
  output logic                   DMemReq,
  output logic                   DMemWe,
  output logic [BIT_COUNT-1:0]   DMemAddr,
  output logic [BIT_COUNT/8-1:0] DMemByteEn,
  output logic [BIT_COUNT-1:0]   DMemWData,
  input  logic                   DMemAck,
  input  logic [BIT_COUNT-1:0]   DMemRData
);

  localparam int LANES = BIT_COUNT / 8;

  memState              state_q, state_d;
  logic [1:0]           off_q, off_d;
  logic [2:0]           size_q, size_d;
  logic                 we_q, we_d;
  logic [BIT_COUNT-1:0] wdata_q, wdata_d;
  logic [BIT_COUNT-1:0] lo_word_q, lo_word_d;
  logic [BIT_COUNT-1:0] load_data_q, load_data_d;
  logic                 dmem_we_q, dmem_we_d;
  logic [BIT_COUNT-1:0] dmem_addr_q, dmem_addr_d;
  logic [LANES-1:0]     dmem_be_q, dmem_be_d;
  logic [BIT_COUNT-1:0] dmem_wdata_q, dmem_wdata_d;

  logic                 idle;
  logic [1:0]           sh_off;
  logic [2:0]           sh_size;
  logic [BIT_COUNT-1:0] sh_store, sh_lo, sh_hi;
  logic [LANES-1:0]     sh_lo_be, sh_hi_be;
  logic [BIT_COUNT-1:0] sh_lo_wdata, sh_hi_wdata, sh_load;
  logic                 sh_span;

  // In IDLE the shifter sees the live request so the lo beat can be registered
  // on the capture edge; afterwards it works from the captured copy.
  always_comb begin
    idle     = (state_q == IDLE);
    sh_off   = idle ? Address[1:0]       : off_q;
    sh_size  = idle ? sizeOf(TruncSrc)   : size_q;
    sh_store = idle ? WriteData          : wdata_q;
    sh_lo    = (state_q == ACC_LO) ? DMemRData : lo_word_q;
    sh_hi    = (state_q == ACC_HI) ? DMemRData : '0;
  end

  lane_shifter #(
    .BIT_COUNT (BIT_COUNT)
  ) u_lane_shifter (
    .off        (sh_off),
    .size       (sh_size),
    .store_data (sh_store),
    .lo_word    (sh_lo),
    .hi_word    (sh_hi),
    .lo_be      (sh_lo_be),
    .hi_be      (sh_hi_be),
    .lo_wdata   (sh_lo_wdata),
    .hi_wdata   (sh_hi_wdata),
    .load_data  (sh_load),
    .span       (sh_span)
  );

  // Sequencing: capture request, run one or two beats, then a single RESP cycle.
  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    lo_word_d    = lo_word_q;
    load_data_d  = load_data_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    case (state_q)
      IDLE: begin
        if (MemReq) begin
          state_d      = ACC_LO;
          off_d        = Address[1:0];
          size_d       = sizeOf(TruncSrc);
          we_d         = MemWrite;
          wdata_d      = WriteData;
          dmem_we_d    = MemWrite;
          dmem_addr_d  = {Address[BIT_COUNT-1:2], 2'b00};
          dmem_be_d    = sh_lo_be;
          dmem_wdata_d = sh_lo_wdata;
        end
      end
      ACC_LO: begin
        if (DMemAck) begin
          if (sh_span) begin
            state_d      = ACC_HI;
            lo_word_d    = DMemRData;
            dmem_addr_d  = dmem_addr_q + BIT_COUNT'(4);
            dmem_be_d    = sh_hi_be;
            dmem_wdata_d = sh_hi_wdata;
          end else begin
            state_d = RESP;
            if (!we_q) load_data_d = sh_load;
          end
        end
      end
      ACC_HI: begin
        if (DMemAck) begin
          state_d = RESP;
          if (!we_q) load_data_d = sh_load;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and bus registers; reset abandons any beat in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      off_q        <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      lo_word_q    <= '0;
      load_data_q  <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= '0;
      dmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      size_q       <= size_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      lo_word_q    <= lo_word_d;
      load_data_q  <= load_data_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
    end
  end

  // Handshake outputs; the IDLE stall term is gated so reset forces Stall low.
  always_comb begin
    DMemReq    = (state_q == ACC_LO) || (state_q == ACC_HI);
    Stall      = (idle && MemReq && reset_n) || DMemReq;
    LoadValid  = (state_q == RESP) && !we_q;
    LoadData   = load_data_q;
    DMemWe     = dmem_we_q;
    DMemAddr   = dmem_addr_q;
    DMemByteEn = dmem_be_q;
    DMemWData  = dmem_wdata_q;
  end

endmodule
`default_nettype wire
